// File: rtl/fir_mac_filter.sv
// Time-multiplexed multi-channel FIR: one shared signed MAC walks every tap of
// every channel's circular history per frame, then rounds/saturates the results.
module fir_mac_filter #(
  parameter int NUM_TAPS = 64,
  parameter int DATA_W   = 16,
  parameter int COEFF_W  = 8,
  parameter int NUM_CH   = 2,
  parameter int SHIFT    = 7,
  localparam int ADDR_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     bypass,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic [COEFF_W-1:0]       coef_data,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     overrun,
  output logic                     sat
);

  localparam int ACC_W   = DATA_W + COEFF_W + ADDR_W;
  localparam int ACC1_W  = ACC_W + 1;
  localparam int PROD_W  = DATA_W + COEFF_W;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int C0_I    = ((2 ** SHIFT) > (2 ** (COEFF_W - 1) - 1)) ?
                           (2 ** (COEFF_W - 1) - 1) : (2 ** SHIFT);

  localparam logic signed [COEFF_W-1:0] C0_RST  = COEFF_W'(C0_I);
  localparam logic [ADDR_W-1:0]         K_LAST  = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0]         TAPS_M  = ADDR_W'(NUM_TAPS);
  localparam logic [ADDR_W:0]           TAPS_X  = (ADDR_W + 1)'(NUM_TAPS);
  localparam logic [CH_W-1:0]           CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic signed [ACC_W:0]     RND     = (SHIFT > 0) ? (ACC1_W'(1) << RND_POS) : '0;
  localparam logic signed [ACC_W:0]     SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]     SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_STORE, S_DONE} state_t;

  state_t                     r_state, w_state_next;
  logic [NUM_CH*DATA_W-1:0]   r_in_data;
  logic                       r_bypass;
  logic signed [COEFF_W-1:0]  r_coef  [NUM_TAPS];
  logic signed [DATA_W-1:0]   r_hist  [NUM_CH][NUM_TAPS];
  logic signed [DATA_W-1:0]   r_stage [NUM_CH];
  logic [ADDR_W-1:0]          r_wr_ptr, r_k;
  logic [CH_W-1:0]            r_ch;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_out_valid, r_overrun, r_sat;
  logic [NUM_CH*DATA_W-1:0]   r_out_data;

  logic [ADDR_W-1:0]          w_rd_idx;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W:0]      w_rnd, w_shift;
  logic signed [DATA_W-1:0]   w_res, w_store_val;
  logic                       w_clip;
  logic [NUM_CH*DATA_W-1:0]   w_out_next;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_MAC;
      S_MAC:   if (r_k == K_LAST) w_state_next = S_STORE;
      S_STORE: w_state_next = (r_ch == CH_LAST) ? S_DONE : S_MAC;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Newest sample sits at wr_ptr; older taps are read backwards with wrap.
  always_comb begin
    w_rd_idx = r_wr_ptr - r_k;
    if (r_wr_ptr < r_k) w_rd_idx = TAPS_M + r_wr_ptr - r_k;
  end

  assign w_prod = r_coef[r_k] * r_hist[r_ch][w_rd_idx];

  always_comb begin
    w_rnd   = ACC1_W'(r_acc) + RND;
    w_shift = w_rnd >>> SHIFT;
    w_clip  = 1'b0;
    w_res   = w_shift[DATA_W-1:0];
    if (w_shift > SAT_MAX) begin
      w_res  = {1'b0, {(DATA_W-1){1'b1}}};
      w_clip = 1'b1;
    end else if (w_shift < SAT_MIN) begin
      w_res  = {1'b1, {(DATA_W-1){1'b0}}};
      w_clip = 1'b1;
    end
    w_store_val = r_bypass ? r_in_data[r_ch*DATA_W +: DATA_W] : w_res;
  end

  always_comb begin
    w_out_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_out_next[c*DATA_W +: DATA_W] = (CH_W'(c) == r_ch) ? w_store_val : r_stage[c];
    end
  end

  // NOTE: histories and coefficients are flops with a reset because both have
  // defined reset contents; a RAM macro could not be cleared in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_data   <= '0;
      r_bypass    <= 1'b0;
      r_wr_ptr    <= '0;
      r_k         <= '0;
      r_ch        <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overrun   <= 1'b0;
      r_sat       <= 1'b0;
      for (int t = 0; t < NUM_TAPS; t++) r_coef[t] <= (t == 0) ? C0_RST : '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_stage[c] <= '0;
        for (int t = 0; t < NUM_TAPS; t++) r_hist[c][t] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (coef_we && (r_state == S_IDLE) && ({1'b0, coef_addr} < TAPS_X))
        r_coef[coef_addr] <= coef_data;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_data <= in_data;
            r_bypass  <= bypass;
          end
        end
        S_LOAD: begin
          for (int c = 0; c < NUM_CH; c++)
            r_hist[c][r_wr_ptr] <= r_in_data[c*DATA_W +: DATA_W];
          r_acc <= '0;
          r_k   <= '0;
          r_ch  <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_k   <= r_k + 1'b1;
        end
        S_STORE: begin
          r_stage[r_ch] <= w_store_val;
          if (!r_bypass && w_clip) r_sat <= 1'b1;
          r_acc <= '0;
          r_k   <= '0;
          if (r_ch == CH_LAST) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_next;
          end else begin
            r_ch <= r_ch + 1'b1;
          end
        end
        S_DONE: r_wr_ptr <= (r_wr_ptr == K_LAST) ? '0 : r_wr_ptr + 1'b1;
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;
  assign sat       = r_sat;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Self-checking bench for fir_mac_filter at default parameters: vector table,
// expected-result queue drained by an out_valid monitor, and corner sequences.
module tb_fir_mac_filter;

  localparam int LAT = 2 + 2 * (64 + 1);

  logic        clk = 1'b0;
  logic        rst_n, in_valid, bypass, coef_we;
  logic [31:0] in_data;
  logic [5:0]  coef_addr;
  logic [7:0]  coef_data;
  logic        out_valid, busy, overrun, sat;
  logic [31:0] out_data;

  fir_mac_filter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .bypass(bypass), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .overrun(overrun), .sat(sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [15:0] e0, e1;
    int                 cyc;
  } exp_t;

  typedef struct {
    logic signed [15:0] d0, d1;
    logic               byp;
    logic signed [15:0] e0, e1;
  } vec_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      check("pending_expect", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("out_ch0", $signed(out_data[15:0]), e.e0);
        check("out_ch1", $signed(out_data[31:16]), e.e1);
        check("latency", cyc, e.cyc);
      end
    end
  end

  function automatic logic signed [15:0] sat_round(input longint acc);
    longint r;
    r = (acc + 64) >>> 7;
    if (r > 32767)  return 16'sh7fff;
    if (r < -32768) return 16'sh8000;
    return 16'(r);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    q.delete();
    rst_n = 1'b1;
  endtask

  task automatic write_coef(input int a, input int v);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 6'(a); coef_data = 8'(v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic send(input logic signed [15:0] d0, d1, input logic byp,
                      input logic signed [15:0] e0, e1);
    exp_t e;
    @(negedge clk);
    in_data = {d1, d0}; bypass = byp; in_valid = 1'b1;
    e.e0 = e0; e.e1 = e1; e.cyc = cyc + LAT;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; bypass = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", n < 1000, 1);
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = '{16'sd1000, -16'sd1000, 1'b0, 16'sd992, -16'sd992};
    tbl[1] = '{16'sd0, 16'sd0, 1'b0, 16'sd0, 16'sd0};
    tbl[2] = '{16'sd0, 16'sd0, 1'b0, 16'sd0, 16'sd0};
    tbl[3] = '{16'sd128, 16'sd0, 1'b0, 16'sd10, 16'sd0};
    tbl[4] = '{16'sd0, 16'sd0, 1'b0, 16'sd20, 16'sd0};
    tbl[5] = '{16'sd0, 16'sd0, 1'b0, 16'sd30, 16'sd0};
    tbl[6] = '{16'sd0, 16'sd0, 1'b0, 16'sd40, 16'sd0};
    tbl[7] = '{16'sd0, 16'sd0, 1'b0, 16'sd0, 16'sd0};

    rst_n = 1'b0; in_valid = 1'b0; bypass = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sat", sat, 0);
    rst_n = 1'b1;

    // Default coefficients, then the 10/20/30/40 tap response.
    for (int i = 0; i < 3; i++) begin
      send(tbl[i].d0, tbl[i].d1, tbl[i].byp, tbl[i].e0, tbl[i].e1);
      wait_idle();
    end
    do_reset();
    for (int k = 0; k < 4; k++) write_coef(k, 10 * (k + 1));
    for (int i = 3; i < 8; i++) begin
      send(tbl[i].d0, tbl[i].d1, tbl[i].byp, tbl[i].e0, tbl[i].e1);
      wait_idle();
    end

    // Saturation in both directions with all taps at 127.
    do_reset();
    for (int k = 0; k < 64; k++) write_coef(k, 127);
    for (int n = 1; n <= 64; n++) begin
      send(16'sd32767, 16'sd0, 1'b0, sat_round(longint'(127) * 32767 * n), 16'sd0);
      wait_idle();
      if (n == 1) check("sat_not_yet", sat, 0);
    end
    check("sat_pos", sat, 1);
    do_reset();
    check("sat_cleared", sat, 0);
    for (int k = 0; k < 64; k++) write_coef(k, 127);
    for (int n = 1; n <= 64; n++) begin
      send(-16'sd32768, 16'sd0, 1'b0, sat_round(longint'(-127) * 32768 * n), 16'sd0);
      wait_idle();
    end
    check("sat_neg", sat, 1);

    // Strobe landing in the DONE cycle is dropped.
    do_reset();
    send(16'sd1000, -16'sd1000, 1'b0, 16'sd992, -16'sd992);
    repeat (LAT - 1) @(negedge clk);
    check("done_cycle_busy", busy, 1);
    in_valid = 1'b1; in_data = {16'sd0, 16'sd7};
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    check("overrun_done", overrun, 1);

    // Strobe and coefficient write 10 cycles into a frame.
    do_reset();
    check("overrun_cleared", overrun, 0);
    send(16'sd1000, 16'sd0, 1'b0, 16'sd992, 16'sd0);
    repeat (9) @(negedge clk);
    in_valid = 1'b1; in_data = {16'sd0, 16'sd5000};
    coef_we = 1'b1; coef_addr = 6'd0; coef_data = 8'd50;
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
    wait_idle();
    check("overrun_busy", overrun, 1);
    repeat (5) @(negedge clk);
    check("out_hold", $signed(out_data[15:0]), 992);
    send(16'sd128, 16'sd0, 1'b0, 16'sd127, 16'sd0);
    wait_idle();

    // Bypass frame still enters the history.
    do_reset();
    write_coef(1, 64);
    send(16'sd1234, -16'sd55, 1'b1, 16'sd1234, -16'sd55);
    wait_idle();
    send(16'sd128, 16'sd0, 1'b0, 16'sd744, -16'sd27);
    wait_idle();
    check("bypass_no_sat", sat, 0);

    // Reset 50 cycles into a frame aborts it.
    do_reset();
    send(16'sd1000, 16'sd0, 1'b0, 16'sd992, 16'sd0);
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_busy", busy, 0);
    check("abort_overrun", overrun, 0);
    check("abort_sat", sat, 0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    write_coef(1, 64);
    send(16'sd128, 16'sd0, 1'b0, 16'sd127, 16'sd0);
    wait_idle();
    send(16'sd0, 16'sd0, 1'b0, 16'sd64, 16'sd0);
    wait_idle();

    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
